non_restoring_div: RTL and testbench
====================================

Name: non_restoring_div

Overview:
- Sequential signed 8-bit integer divider using the non-restoring algorithm.
- Computes a / b with the quotient truncated toward zero, sign-extended to 16 bits.
- Start/done handshake; one result per request; one iteration per clock.
- Used as the division unit of the ALU datapath.

Parameters:
- WIDTH, 8, operand width in bits. The quotient output is 2*WIDTH bits. All figures below assume WIDTH=8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  request pulse; sampled on the rising edge while the block is IDLE or DONE
- a  input  8  signed dividend (two's complement)
- b  input  8  signed divisor (two's complement)
- quotient  output  16  signed quotient, truncated toward zero, sign-extended
- done  output  1  result-valid flag; held high until the next accepted start

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, quotient=0, done=0, all internal registers cleared. Reset mid-operation aborts the division and discards its result.
- States: IDLE, CALC, FIX, DONE.
- IDLE or DONE with start=1 at a clock edge (accept edge):
  - latch |a| and |b| as 8-bit unsigned magnitudes (-128 gives 8'h80);
  - latch result sign = a[7] XOR b[7] and a divide-by-zero flag (b==0);
  - clear the 9-bit signed partial remainder P, load Q=|a|, set counter=0;
  - clear done; go to CALC.
- quotient keeps its previous value until the new result is written.
- CALC, one iteration per edge, 8 iterations:
  - shift {P,Q} left by 1;
  - if P was non-negative before the shift, P = P - |b|; otherwise P = P + |b|;
  - Q[0] = NOT sign(new P);
  - after the 8th iteration go to FIX.
- FIX, one edge:
  - magnitude = Q;
  - the remainder correction (P = P + |b| when P < 0) is internal only; the remainder is not output;
  - quotient = 0 if divide-by-zero; else the sign-extended magnitude, negated when the result sign is 1;
  - done=1; go to DONE.
- DONE: done and quotient held stable. start=1 is handled as in IDLE. start=0 stays in DONE.
- Latency: start accepted at edge k → quotient valid and done=1 after edge k+9. The latency is the same for divide-by-zero.
- start while in CALC or FIX is ignored; no restart and no queuing.
- a and b are sampled only at the accept edge. Later changes have no effect.
- Arithmetic rules:
  - truncation toward zero;
  - the remainder, if computed, takes the sign of the dividend;
  - -128 / -1 = +128, which must be representable in the 16-bit output;
  - any value / 0 = 0, with no error flag.
- done is a level, not a pulse. It is cleared on the edge that accepts the next start.

Test Plan:
- Sign combinations: 25/5 → 5; -25/5 → -5; 25/-5 → -5; -25/-5 → 5. Each with done rising exactly 9 cycles after the accept edge.
- Truncation and extremes: 127/3 → 42; -128/7 → -18; 54/7 → 7; -54/7 → -7; -128/-1 → 128; 0/5 → 0.
- Divide by zero: 5/0 → quotient 0, done=1 after 9 cycles. A following 25/5 → 5.
- Handshake: start pulsed while in CALC is ignored and the first result completes. done stays high through idle cycles, drops on the edge accepting the next start, and quotient holds its old value until the new result is written.
- Reset: assert reset=0 mid-CALC → quotient=0 and done=0 immediately (asynchronous). After release, a fresh 54/7 → 7.
- Back-to-back: start asserted in the first DONE cycle. The new operation begins immediately and returns a correct result 9 cycles later.

Source files
------------

// File: rtl/non_restoring_div.sv
// Sequential signed divider using the non-restoring algorithm.
// Computes a / b truncated toward zero; the quotient is sign-extended to
// 2*WIDTH bits so that -2^(WIDTH-1) / -1 is representable. Division by
// zero returns 0. One iteration per clock; result valid WIDTH+1 edges
// after the accepting edge and held until the next accepted start.
module non_restoring_div #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   quotient,
  output logic                 done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Operand magnitudes, result sign and divide-by-zero flag
  logic [WIDTH-1:0] mag_b_reg;
  logic             neg_reg;
  logic             dz_reg;
  // Partial remainder (one guard bit for its sign) and quotient/dividend shift register
  logic [WIDTH:0]   p_reg;
  logic [WIDTH-1:0] q_reg;
  logic [CW-1:0]    cnt_reg;

  logic             accept;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   p_iter;
  logic [WIDTH-1:0] q_iter;
  logic [2*WIDTH-1:0] mag_ext;
  logic [2*WIDTH-1:0] result;

  // A new request is only taken when no division is in flight
  assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));

  // Two's complement magnitudes; the most negative value maps to 2^(WIDTH-1)
  assign mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;

  // One non-restoring step: shift {P,Q} left, then subtract or add the divisor
  // depending on the sign of P before the shift. The shifted value always fits
  // in WIDTH+1 bits because |P| stays below |b| between steps.
  always_comb begin
    p_shift = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    if (p_reg[WIDTH]) begin
      p_iter = p_shift + {1'b0, mag_b_reg};
    end else begin
      p_iter = p_shift - {1'b0, mag_b_reg};
    end
    q_iter = {q_reg[WIDTH-2:0], ~p_iter[WIDTH]};
  end

  // Final signed result from the unsigned quotient magnitude
  always_comb begin
    mag_ext = {{WIDTH{1'b0}}, q_reg};
    if (dz_reg) begin
      result = '0;
    end else if (neg_reg) begin
      result = ~mag_ext + 1'b1;
    end else begin
      result = mag_ext;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (cnt_reg == LAST_ITER) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    if (accept) state_next = CALC;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, remainder correction, result write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mag_b_reg <= '0;
      neg_reg   <= 1'b0;
      dz_reg    <= 1'b0;
      p_reg     <= '0;
      q_reg     <= '0;
      cnt_reg   <= '0;
      quotient  <= '0;
      done      <= 1'b0;
    end else begin
      if (accept) begin
        mag_b_reg <= mag_b;
        neg_reg   <= a[WIDTH-1] ^ b[WIDTH-1];
        dz_reg    <= (b == '0);
        p_reg     <= '0;
        q_reg     <= mag_a;
        cnt_reg   <= '0;
        done      <= 1'b0;
      end else if (state_reg == CALC) begin
        p_reg   <= p_iter;
        q_reg   <= q_iter;
        cnt_reg <= cnt_reg + 1'b1;
      end else if (state_reg == FIX) begin
        // Remainder correction keeps P consistent; P itself is not exported
        if (p_reg[WIDTH]) begin
          p_reg <= p_reg + {1'b0, mag_b_reg};
        end
        quotient <= result;
        done     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_non_restoring_div.sv
// Directed self-checking bench for non_restoring_div (WIDTH=8).
module tb_non_restoring_div;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] quotient;
  logic        done;

  int errors = 0;
  int checks = 0;

  non_restoring_div #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .quotient (quotient),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one division, check done stays low through edge k+8, then check
  // done=1 and the quotient right after edge k+9. Leaves the DUT in its
  // first DONE cycle.
  task automatic do_div(input string tag, input int av, input int bv, input int qv);
    logic [15:0] exp_q;
    exp_q = 16'(qv);
    a     = 8'(av);
    b     = 8'(bv);
    start = 1'b1;
    tick();                 // accept edge k
    start = 1'b0;
    check({tag, "_done_clr"}, {15'd0, done}, 16'd0);
    for (int i = 0; i < 7; i++) tick();   // edges k+1..k+7
    tick();                                // edge k+8
    check({tag, "_done_early"}, {15'd0, done}, 16'd0);
    tick();                                // edge k+9
    check({tag, "_done"}, {15'd0, done}, 16'd1);
    check({tag, "_q"}, quotient, exp_q);
    $display("div %0d / %0d -> quotient=%0d (expected %0d)", av, bv,
             $signed(quotient), $signed(exp_q));
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    a     = 8'd0;
    b     = 8'd0;
    #2;
    check("reset_q", quotient, 16'h0000);
    check("reset_done", {15'd0, done}, 16'd0);
    #10;
    reset = 1'b1;
    tick();

    // Sign combinations
    do_div("p25_p5",   25,   5,    5);
    do_div("n25_p5",  -25,   5,   -5);
    do_div("p25_n5",   25,  -5,   -5);
    do_div("n25_n5",  -25,  -5,    5);

    // Truncation and extremes (back-to-back: each starts in the first DONE cycle)
    do_div("p127_p3",  127,  3,   42);
    do_div("n128_p7", -128,  7,  -18);
    do_div("p54_p7",    54,  7,    7);
    do_div("n54_p7",   -54,  7,   -7);
    do_div("n128_n1", -128, -1,  128);
    do_div("z_p5",       0,  5,    0);

    // Divide by zero, then a normal division
    do_div("p5_z",       5,  0,    0);
    do_div("after_dz",  25,  5,    5);

    // Handshake: done held through idle cycles
    for (int i = 0; i < 3; i++) tick();
    check("hold_done", {15'd0, done}, 16'd1);
    check("hold_q", quotient, 16'd5);
    $display("idle hold: done=%0b quotient=%0d", done, $signed(quotient));

    // New start: done drops, quotient keeps old value; start in CALC ignored
    a = 8'd54; b = 8'd7; start = 1'b1;
    tick();                 // accept edge k
    start = 1'b0;
    check("hs_done_clr", {15'd0, done}, 16'd0);
    check("hs_q_held", quotient, 16'd5);
    tick(); tick();         // k+2, in CALC
    a = 8'd100; b = 8'd1; start = 1'b1;
    tick();                 // k+3, must be ignored
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();   // k+4..k+8
    check("hs_done_early", {15'd0, done}, 16'd0);
    check("hs_q_still_held", quotient, 16'd5);
    tick();                 // k+9
    check("hs_done", {15'd0, done}, 16'd1);
    check("hs_q", quotient, 16'd7);
    for (int i = 0; i < 12; i++) tick();
    check("hs_no_queue_done", {15'd0, done}, 16'd1);
    check("hs_no_queue_q", quotient, 16'd7);
    $display("handshake: ignored start, quotient=%0d done=%0b", $signed(quotient), done);

    // Asynchronous reset mid-CALC
    a = 8'd127; b = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_q", quotient, 16'h0000);
    check("rst_async_done", {15'd0, done}, 16'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    check("rst_no_result_done", {15'd0, done}, 16'd0);
    check("rst_no_result_q", quotient, 16'h0000);
    $display("reset mid-calc: quotient=%0d done=%0b", $signed(quotient), done);
    do_div("post_rst", 54, 7, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
